// File: rtl/dmux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
// Holds the lane count, the lane select encodings and the lane index type.
package dmux_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_idx_t;

  localparam lane_idx_t SEL_A = 2'b00;
  localparam lane_idx_t SEL_B = 2'b01;
  localparam lane_idx_t SEL_C = 2'b10;
  localparam lane_idx_t SEL_D = 2'b11;

endpackage

// File: rtl/lane_fifo2.sv
// Two-entry FIFO for one demux lane.
// The head word is kept in its own register so it holds its last value once the lane empties.
module lane_fifo2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] head_q, head_d;
  logic             wrPtr_q, wrPtr_d;
  logic             rdPtr_q, rdPtr_d;
  logic [1:0]       count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign data_o  = head_q;

  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;

  // The next head comes straight from data_i when this cycle's push lands in the slot
  // that becomes the head (empty lane, or push and pop together at occupancy 1).
  always_comb begin
    wrPtr_d = wrPtr_q ^ doPush;
    rdPtr_d = rdPtr_q ^ doPop;
    count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
    head_d  = head_q;
    if (count_d != 2'd0) begin
      if (doPush && (wrPtr_q == rdPtr_d)) begin
        head_d = data_i;
      end else begin
        head_d = mem_q[rdPtr_d];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= '0;
      wrPtr_q  <= 1'b0;
      rdPtr_q  <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      head_q  <= head_d;
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/dmux4way16_stream.sv
// Registered 1-to-4 stream demultiplexer: steers each accepted word into the lane named
// by in_sel_i, where a two-entry FIFO buffers it for that lane's consumer.
module dmux4way16_stream
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [1:0]       in_sel_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] a_data_o,
  output logic [WIDTH-1:0] b_data_o,
  output logic [WIDTH-1:0] c_data_o,
  output logic [WIDTH-1:0] d_data_o,
  output logic             a_valid_o,
  output logic             b_valid_o,
  output logic             c_valid_o,
  output logic             d_valid_o,
  input  logic             a_ready_i,
  input  logic             b_ready_i,
  input  logic             c_ready_i,
  input  logic             d_ready_i
);

  if (DEPTH != 2) begin : g_depth_check
    $error("dmux4way16_stream supports only DEPTH = 2");
  end

  lane_idx_t        laneSel;
  logic [WIDTH-1:0] laneData [LANES];
  logic [LANES-1:0] laneEmpty;
  logic [LANES-1:0] laneFull;
  logic [LANES-1:0] laneReady;
  logic [LANES-1:0] lanePush;

  assign laneSel   = lane_idx_t'(in_sel_i);
  assign laneReady = {d_ready_i, c_ready_i, b_ready_i, a_ready_i};

  // Ready depends only on the selected lane's occupancy, never on consumer readies.
  assign in_ready_o = !laneFull[laneSel] && !rst_i;

  always_comb begin
    lanePush = '0;
    if (in_valid_i && in_ready_o) begin
      lanePush[laneSel] = 1'b1;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (lanePush[l]),
      .data_i  (in_data_i),
      .pop_i   (laneReady[l]),
      .full_o  (laneFull[l]),
      .empty_o (laneEmpty[l]),
      .data_o  (laneData[l])
    );
  end

  assign a_data_o  = laneData[SEL_A];
  assign b_data_o  = laneData[SEL_B];
  assign c_data_o  = laneData[SEL_C];
  assign d_data_o  = laneData[SEL_D];
  assign a_valid_o = !laneEmpty[SEL_A];
  assign b_valid_o = !laneEmpty[SEL_B];
  assign c_valid_o = !laneEmpty[SEL_C];
  assign d_valid_o = !laneEmpty[SEL_D];

endmodule

// File: tb/tb_dmux4way16_stream.sv
// Directed and random checks for the 1-to-4 stream demultiplexer.
// Inputs change 1ns after the rising edge; outputs are sampled away from the edge.
module tb_dmux4way16_stream;

  localparam int WIDTH = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [WIDTH-1:0] in_data_i;
  logic [1:0]       in_sel_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_data_o, b_data_o, c_data_o, d_data_o;
  logic             a_valid_o, b_valid_o, c_valid_o, d_valid_o;
  logic             a_ready_i, b_ready_i, c_ready_i, d_ready_i;

  logic [WIDTH-1:0] obsData [4];
  logic [3:0]       obsValid;

  int checkCount = 0;
  int failCount  = 0;

  dmux4way16_stream #(.WIDTH(WIDTH), .DEPTH(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_data_i  (in_data_i),
    .in_sel_i   (in_sel_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .a_data_o   (a_data_o),
    .b_data_o   (b_data_o),
    .c_data_o   (c_data_o),
    .d_data_o   (d_data_o),
    .a_valid_o  (a_valid_o),
    .b_valid_o  (b_valid_o),
    .c_valid_o  (c_valid_o),
    .d_valid_o  (d_valid_o),
    .a_ready_i  (a_ready_i),
    .b_ready_i  (b_ready_i),
    .c_ready_i  (c_ready_i),
    .d_ready_i  (d_ready_i)
  );

  always #5 clk_i = ~clk_i;

  assign obsData[0] = a_data_o;
  assign obsData[1] = b_data_o;
  assign obsData[2] = c_data_o;
  assign obsData[3] = d_data_o;
  assign obsValid   = {d_valid_o, c_valid_o, b_valid_o, a_valid_o};

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleInputs();
    in_valid_i = 1'b0;
    in_sel_i   = 2'b00;
    in_data_i  = '0;
  endtask

  task automatic setReadies(input logic [3:0] r);
    a_ready_i = r[0];
    b_ready_i = r[1];
    c_ready_i = r[2];
    d_ready_i = r[3];
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #2;
    for (int l = 0; l < 4; l++) begin
      checkCount++;
      if (obsValid[l] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset_valid lane %0d: got %b expected 0", l, obsValid[l]);
      end
      checkCount++;
      if (obsData[l] !== 16'h0000) begin
        failCount++;
        $display("[TB] FAIL reset_data lane %0d: got %h expected 0000", l, obsData[l]);
      end
    end
    checkCount++;
    if (in_ready_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel_i = 2'(s);
      #1;
      checkCount++;
      if (in_ready_o !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL post_reset_ready sel %0d: got %b expected 1", s, in_ready_o);
      end
    end
    idleInputs();
    step();
  endtask

  task automatic test_routing();
    logic [15:0] words [4];
    words[0] = 16'h1111;
    words[1] = 16'h2222;
    words[2] = 16'h3333;
    words[3] = 16'h4444;
    setReadies(4'b1111);
    in_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sel_i  = 2'(k);
      in_data_i = words[k];
      step();
      checkCount++;
      if (obsValid[k] !== 1'b1 || obsData[k] !== words[k]) begin
        failCount++;
        $display("[TB] FAIL routing lane %0d: got valid %b data %h expected valid 1 data %h",
                 k, obsValid[k], obsData[k], words[k]);
      end
      if (k > 0) begin
        checkCount++;
        if (obsValid[k-1] !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL routing_one_cycle lane %0d: got valid %b expected 0", k - 1, obsValid[k-1]);
        end
      end
    end
    idleInputs();
    step();
    checkCount++;
    if (obsValid !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL routing_drained: got valids %b expected 0000", obsValid);
    end
  endtask

  task automatic test_fill();
    setReadies(4'b1011);
    in_valid_i = 1'b1;
    in_sel_i   = 2'b10;
    in_data_i  = 16'hAAAA;
    #1;
    checkCount++;
    if (in_ready_o !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL fill_ready_0: got %b expected 1", in_ready_o);
    end
    step();
    in_data_i = 16'hBBBB;
    #1;
    checkCount++;
    if (in_ready_o !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL fill_ready_1: got %b expected 1", in_ready_o);
    end
    step();
    in_data_i = 16'hCCCC;
    #1;
    checkCount++;
    if (in_ready_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL fill_ready_full: got %b expected 0", in_ready_o);
    end
    step();
    checkCount++;
    if (c_valid_o !== 1'b1 || c_data_o !== 16'hAAAA || in_ready_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL fill_stalled: got valid %b data %h ready %b expected 1 AAAA 0",
               c_valid_o, c_data_o, in_ready_o);
    end
    c_ready_i = 1'b1;
    step();
    checkCount++;
    if (c_data_o !== 16'hBBBB || in_ready_o !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL fill_first_pop: got data %h ready %b expected BBBB 1", c_data_o, in_ready_o);
    end
    step();
    idleInputs();
    checkCount++;
    if (c_valid_o !== 1'b1 || c_data_o !== 16'hCCCC) begin
      failCount++;
      $display("[TB] FAIL fill_third_word: got valid %b data %h expected 1 CCCC", c_valid_o, c_data_o);
    end
    step();
    checkCount++;
    if (c_valid_o !== 1'b0 || c_data_o !== 16'hCCCC) begin
      failCount++;
      $display("[TB] FAIL fill_drained_hold: got valid %b data %h expected 0 CCCC", c_valid_o, c_data_o);
    end
  endtask

  task automatic test_isolation();
    setReadies(4'b1110);
    in_valid_i = 1'b1;
    in_sel_i   = 2'b00;
    in_data_i  = 16'h0A01;
    step();
    in_data_i  = 16'h0A02;
    step();
    checkCount++;
    if (a_valid_o !== 1'b1 || a_data_o !== 16'h0A01) begin
      failCount++;
      $display("[TB] FAIL iso_a_full: got valid %b data %h expected 1 0A01", a_valid_o, a_data_o);
    end
    for (int r = 0; r < 3; r++) begin
      in_sel_i  = 2'b00;
      in_data_i = 16'h0AF0 + 16'(r);
      #1;
      checkCount++;
      if (in_ready_o !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL iso_ready_a round %0d: got %b expected 0", r, in_ready_o);
      end
      step();
      checkCount++;
      if (a_data_o !== 16'h0A01) begin
        failCount++;
        $display("[TB] FAIL iso_a_unchanged round %0d: got %h expected 0A01", r, a_data_o);
      end
      in_sel_i  = 2'b11;
      in_data_i = 16'hD000 + 16'(r);
      #1;
      checkCount++;
      if (in_ready_o !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL iso_ready_d round %0d: got %b expected 1", r, in_ready_o);
      end
      step();
      checkCount++;
      if (d_valid_o !== 1'b1 || d_data_o !== 16'hD000 + 16'(r)) begin
        failCount++;
        $display("[TB] FAIL iso_d_word round %0d: got valid %b data %h expected 1 %h",
                 r, d_valid_o, d_data_o, 16'hD000 + 16'(r));
      end
    end
    idleInputs();
    step();
    a_ready_i = 1'b1;
    step();
    checkCount++;
    if (a_valid_o !== 1'b1 || a_data_o !== 16'h0A02) begin
      failCount++;
      $display("[TB] FAIL iso_a_second: got valid %b data %h expected 1 0A02", a_valid_o, a_data_o);
    end
    step();
    checkCount++;
    if (obsValid !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL iso_drained: got valids %b expected 0000", obsValid);
    end
  endtask

  task automatic test_push_pop();
    setReadies(4'b1111);
    in_valid_i = 1'b1;
    in_sel_i   = 2'b01;
    in_data_i  = 16'h0001;
    step();
    checkCount++;
    if (b_valid_o !== 1'b1 || b_data_o !== 16'h0001) begin
      failCount++;
      $display("[TB] FAIL pushpop_first: got valid %b data %h expected 1 0001", b_valid_o, b_data_o);
    end
    in_data_i = 16'h0002;
    #1;
    checkCount++;
    if (in_ready_o !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL pushpop_ready: got %b expected 1", in_ready_o);
    end
    step();
    idleInputs();
    checkCount++;
    if (b_valid_o !== 1'b1 || b_data_o !== 16'h0002) begin
      failCount++;
      $display("[TB] FAIL pushpop_second: got valid %b data %h expected 1 0002", b_valid_o, b_data_o);
    end
    step();
    checkCount++;
    if (b_valid_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL pushpop_occupancy_one: got valid %b expected 0", b_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    setReadies(4'b1101);
    in_valid_i = 1'b1;
    in_sel_i   = 2'b01;
    in_data_i  = 16'hB0B1;
    step();
    in_data_i  = 16'hB0B2;
    step();
    in_valid_i = 1'b0;
    checkCount++;
    if (b_valid_o !== 1'b1 || b_data_o !== 16'hB0B1 || in_ready_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rstmid_before: got valid %b data %h ready %b expected 1 B0B1 0",
               b_valid_o, b_data_o, in_ready_o);
    end
    #3;
    rst_i = 1'b1;
    #1;
    checkCount++;
    if (b_valid_o !== 1'b0 || b_data_o !== 16'h0000 || in_ready_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rstmid_during: got valid %b data %h ready %b expected 0 0000 0",
               b_valid_o, b_data_o, in_ready_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    checkCount++;
    if (in_ready_o !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL rstmid_ready_after: got %b expected 1", in_ready_o);
    end
    step();
    checkCount++;
    if (b_valid_o !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rstmid_b_empty: got valid %b expected 0", b_valid_o);
    end
    idleInputs();
    setReadies(4'b1111);
  endtask

  task automatic test_soak();
    logic [WIDTH-1:0] modelQ [4][$];
    logic [3:0]       readyVec;
    logic             modelReady;
    idleInputs();
    setReadies(4'b1111);
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk_i);
      #1;
      in_valid_i = 1'($urandom_range(0, 1));
      in_sel_i   = 2'($urandom_range(0, 3));
      in_data_i  = 16'($urandom);
      readyVec   = 4'($urandom);
      setReadies(readyVec);
      #3;
      modelReady = (modelQ[in_sel_i].size() < 2);
      checkCount++;
      if (in_ready_o !== modelReady) begin
        failCount++;
        $display("[TB] FAIL soak_in_ready cycle %0d: got %b expected %b", i, in_ready_o, modelReady);
      end
      for (int l = 0; l < 4; l++) begin
        checkCount++;
        if (obsValid[l] !== (modelQ[l].size() != 0)) begin
          failCount++;
          $display("[TB] FAIL soak_valid cycle %0d lane %0d: got %b expected %b",
                   i, l, obsValid[l], modelQ[l].size() != 0);
        end else if (modelQ[l].size() != 0 && obsData[l] !== modelQ[l][0]) begin
          failCount++;
          $display("[TB] FAIL soak_data cycle %0d lane %0d: got %h expected %h",
                   i, l, obsData[l], modelQ[l][0]);
        end
      end
      for (int l = 0; l < 4; l++) begin
        if (modelQ[l].size() != 0 && readyVec[l]) begin
          void'(modelQ[l].pop_front());
        end
      end
      if (in_valid_i && modelReady) begin
        modelQ[in_sel_i].push_back(in_data_i);
      end
    end
    @(posedge clk_i);
    #1;
    idleInputs();
  endtask

  initial begin
    idleInputs();
    setReadies(4'b1111);
    test_reset();
    test_routing();
    test_fill();
    test_isolation();
    test_push_pop();
    test_reset_mid();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
